// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M iterative multiply/divide unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int CW   = $clog2(XLEN);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  // Decoded view of funct3: which datapath, which operands are signed,
  // and whether the upper half (MULH*) / remainder (REM*) is selected.
  typedef struct packed {
    logic is_div;
    logic a_signed;
    logic b_signed;
    logic sel_hi;
  } op_dec_t;

  // Result of the special-case check (divide by zero, signed overflow,
  // multiply by zero).
  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] val;
  } special_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // 2'b{a_signed, b_signed}
  function automatic logic [1:0] is_signed(input logic [2:0] f3);
    logic [1:0] s;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: s = 2'b11;
      F3_MULHSU:               s = 2'b10;
      default:                 s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic op_dec_t decode_op(input logic [2:0] f3);
    op_dec_t    d;
    logic [1:0] s;
    s          = is_signed(f3);
    d.is_div   = is_div(f3);
    d.a_signed = s[1];
    d.b_signed = s[0];
    d.sel_hi   = f3[2] ? f3[1] : (f3 != F3_MUL);
    return d;
  endfunction

  // Architecturally defined results that do not come out of the plain
  // magnitude datapath (or that can be skipped entirely).
  function automatic special_t special_result(input logic [2:0]      f3,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    special_t sp;
    sp.hit = 1'b0;
    sp.val = '0;
    if (f3[2]) begin
      if (b == '0) begin
        sp.hit = 1'b1;
        sp.val = f3[1] ? a : '1;
      end else if (!f3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
        sp.hit = 1'b1;
        sp.val = f3[1] ? '0 : a;
      end
    end else if (a == '0 || b == '0) begin
      sp.hit = 1'b1;
      sp.val = '0;
    end
    return sp;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// Latency: n/a (wiring only).
// Backpressure: stall is the unit's hold request to the pipeline.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  // Pipeline side: issues operations and consumes results.
  modport master (
    output start, Funct3, SrcA, SrcB, flush,
    input  stall, busy, done, Result
  );

  // Unit side.
  modport slave (
    input  start, Funct3, SrcA, SrcB, flush,
    output stall, busy, done, Result
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: add-or-pass (multiply) or trial subtract (divide).
// Latency: combinational.
// Backpressure: none.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Multiply: {hi,lo} with multiplier in lo; add multiplicand on lo[0], shift right.
  // Divide: {rem,quot}; shift left, keep the subtraction when the divisor fits.
  always_comb begin
    sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
    rem_sh  = acc_in[2*XLEN-1:XLEN-1];
    fits    = (rem_sh >= {1'b0, opnd});
    diff    = rem_sh[XLEN-1:0] - opnd;
    acc_out = {sum, acc_in[XLEN-1:1]};
    if (is_div) begin
      if (fits) begin
        acc_out = {diff, acc_in[XLEN-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide with its own FSM; MULDIV_EARLY_OUT_EN skips CALC for special cases.
// Latency: XLEN+3 cycles start-to-done (2 for early-out cases when MULDIV_EARLY_OUT_EN is defined).
// Backpressure: stall holds the pipeline from accepted start until the DONE cycle; flush aborts.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  muldiv_if.slave bus
);

  state_t            state;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     count_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   res_q;

  op_dec_t           dec;
  special_t          sp;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;
  logic [2*XLEN-1:0] step_acc;

  muldiv_step u_step (
    .is_div  (dec.is_div),
    .acc_in  (acc_q),
    .opnd    (opnd_q),
    .acc_out (step_acc)
  );

  // Operand magnitudes for PREP and the sign-corrected, selected result for FIX.
  always_comb begin
    dec   = decode_op(f3_q);
    sp    = special_result(f3_q, a_q, b_q);
    a_neg = dec.a_signed & a_q[XLEN-1];
    b_neg = dec.b_signed & b_q[XLEN-1];
    a_mag = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag = b_neg ? (~b_q + 1'b1) : b_q;
    prod  = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem   = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    if (sp.hit) begin
      fix_res = sp.val;
    end else if (dec.is_div) begin
      fix_res = dec.sel_hi ? rem : quot;
    end else begin
      fix_res = dec.sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

  // Sequencing FSM with the counter, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else if (bus.flush) begin
      // Abort: Result keeps its last completed value.
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            f3_q   <= bus.Funct3;
            a_q    <= bus.SrcA;
            b_q    <= bus.SrcB;
            busy_q <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          count_q <= CW'(XLEN-1);
          if (dec.is_div) begin
            acc_q  <= {{XLEN{1'b0}}, a_mag};
            opnd_q <= b_mag;
            // Remainder follows the dividend's sign, quotient the xor.
            neg_q  <= dec.sel_hi ? a_neg : (a_neg ^ b_neg);
          end else begin
            acc_q  <= {{XLEN{1'b0}}, b_mag};
            opnd_q <= a_mag;
            neg_q  <= a_neg ^ b_neg;
          end
`ifdef MULDIV_EARLY_OUT_EN
          if (sp.hit) begin
            res_q  <= sp.val;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            state  <= CALC;
          end
`else
          state <= CALC;
`endif
        end
        CALC: begin
          acc_q   <= step_acc;
          count_q <= count_q - 1'b1;
          if (count_q == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          res_q  <= fix_res;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall  = ((state == IDLE) & bus.start & ~bus.flush) | busy_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.Result = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: results, latency, stall, flush and reset.
// Latency: expects XLEN+3 (or 2 for early-out cases under MULDIV_EARLY_OUT_EN).
// Backpressure: checks stall over the whole operation and low in DONE.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;

  muldiv_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int FULL_LAT = XLEN + 3;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = XLEN + 3;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] last_exp = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1 with the unit idle. poke>0 pulses a
  // second start (with altered operands) in that cycle after E0.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int poke);
    int   lat;
    logic stall_ok;
    bus.Funct3 = f3;
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.start  = 1'b1;
    #1;
    chk({tag, "_stall_c0"}, 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat       = 1;
    stall_ok  = 1'b1;
    while (!bus.done && lat < 60) begin
      if (!bus.stall) stall_ok = 1'b0;
      bus.start = (lat == poke);
      if (lat == poke) begin
        bus.Funct3 = F3_MUL;
        bus.SrcA   = 32'h0000_dead;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
    chk({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
    chk({tag, "_result"}, bus.Result, exp);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_result_hold"}, bus.Result, exp);
    last_exp = exp;
  endtask

  initial begin
    int ndone;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.Funct3 = '0;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_busy",   32'(bus.busy),  32'd0);
    chk("rst_done",   32'(bus.done),  32'd0);
    chk("rst_result", bus.Result,     32'd0);
    chk("rst_stall",  32'(bus.stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_neg",     F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT, 0);
    run_op("mulh_min",    F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, FULL_LAT, 0);
    run_op("mulhu_max",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT, 0);
    run_op("mulhsu",      F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FULL_LAT, 0);
    run_op("div_neg",     F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, FULL_LAT, 0);
    run_op("rem_neg",     F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, FULL_LAT, 0);
    run_op("divu_by0",    F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, EO_LAT,   0);
    run_op("remu_by0",    F3_REMU,   32'd5,         32'd0,         32'd5,         EO_LAT,   0);
    run_op("div_ovf",     F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EO_LAT,   0);
    run_op("rem_ovf",     F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         EO_LAT,   0);
    run_op("mul_zero",    F3_MUL,    32'd0,         32'h0001_2345, 32'd0,         EO_LAT,   0);
    run_op("rem_by0",     F3_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, EO_LAT,   0);
    run_op("divu_poke",   F3_DIVU,   32'd100,       32'd7,         32'd14,        FULL_LAT, 5);
    run_op("remu",        F3_REMU,   32'd100,       32'd7,         32'd2,         FULL_LAT, 0);

    // Flush at the 10th CALC cycle (cycle 11 after E0).
    bus.Funct3 = F3_DIVU;
    bus.SrcA   = 32'd1000;
    bus.SrcB   = 32'd3;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("flush_busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy",  32'(bus.busy),  32'd0);
    chk("flush_stall", 32'(bus.stall), 32'd0);
    ndone = 0;
    repeat (40) begin
      if (bus.done) ndone++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_result",  bus.Result, last_exp);

    // flush beats start in IDLE.
    bus.Funct3 = F3_MUL;
    bus.SrcA   = 32'd9;
    bus.SrcB   = 32'd9;
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    #1;
    chk("fs_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("fs_busy", 32'(bus.busy), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("fs_result", bus.Result, last_exp);

    // Asynchronous reset mid-CALC.
    bus.Funct3 = F3_MULHU;
    bus.SrcA   = 32'hFFFF_FFFF;
    bus.SrcB   = 32'hFFFF_FFFF;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy",   32'(bus.busy),  32'd0);
    chk("arst_done",   32'(bus.done),  32'd0);
    chk("arst_result", bus.Result,     32'd0);
    chk("arst_stall",  32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst", F3_MUL, 32'd3, 32'd4, 32'd12, FULL_LAT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute backstop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the main ALU in the execute stage. It accepts one M-extension operation (selected by funct3) from the decode/ALU-control path, runs a shared one-bit-per-cycle shift/add–subtract datapath, and raises a stall until the result is ready. Pipeline flushes abort it cleanly.

## Interface
- XLEN, 32, operand/result width; the counter is $clog2(XLEN) bits wide.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  XLEN  rs1 value (multiplicand / dividend)
- SrcB  in  XLEN  rs2 value (multiplier / divisor)
- flush  in  1  synchronous abort from hazard/branch logic
- stall  out  1  hold the pipeline (combinational)
- busy  out  1  registered; high in PREP, CALC and FIX
- done  out  1  registered; one-cycle pulse with a valid result
- Result  out  XLEN  registered; holds its value until the next done

## Operation
- The FSM has five states: IDLE, PREP, CALC, FIX and DONE.
- IDLE → PREP when start & !flush.
  - Latch Funct3, SrcA and SrcB.
- PREP:
  - Take absolute values of signed operands: MULH and DIV/REM treat both operands as signed; MULHSU treats only SrcA as signed.
  - Record the result sign and clear the 2·XLEN accumulator.
  - Load count = XLEN−1.
- CALC runs for XLEN cycles, one bit per cycle:
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - count decrements; leave for FIX when count==0.
- FIX:
  - Apply sign correction.
  - Select the result: the low half for MUL, the high half for MULH*, the quotient for DIV*, the remainder for REM*.
  - Load Result.
- DONE: done=1 for one cycle, then → IDLE.
- Special results are mandatory in both configurations:
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give SrcA.
  - DIV with SrcA=0x80000000 and SrcB=0xFFFFFFFF gives 0x80000000; REM gives 0.
- stall = (IDLE & start & !flush) | busy. It is low in DONE, so the pipeline advances in the same cycle Result is consumed.
- Boundary conditions:
  - start while not IDLE is ignored.
  - flush in any state → IDLE at the next edge: done stays 0 and Result is unchanged.
  - flush and start together in IDLE: flush wins.
  - A reset mid-operation returns to IDLE immediately.
- Reset values: state IDLE, busy 0, done 0, Result 0, count 0.

## Timing
- Let edge E0 be the edge that samples start. PREP runs in the cycle after E0.
- CALC occupies the next XLEN cycles, followed by one FIX cycle.
- done is high in cycle XLEN+3 after E0, i.e. 35 for XLEN=32.
- A new start is accepted in the cycle after DONE at the earliest, so back-to-back throughput is one operation per XLEN+4 cycles.
- Result is stable from the DONE cycle until the next FIX.

## Configuration
- MULDIV_EARLY_OUT_EN
  - Defined: PREP detects the early-out cases and goes straight to DONE, with Result loaded in PREP, so done rises 2 cycles after E0. The cases are:
    - divisor zero;
    - the signed-overflow DIV/REM pair;
    - either multiply operand zero (Result 0).
  - Undefined: every operation takes the full XLEN+3 latency. Special cases are still produced by the FIX logic with identical values.

## Structure
- muldiv_pkg holds:
  - the state_t enum (IDLE, PREP, CALC, FIX, DONE);
  - localparams for the eight Funct3 codes;
  - an is_div/is_signed decode function shared with the ALU controller.
- One sub-module, muldiv_step: a purely combinational single iteration (add-or-pass for multiply, trial subtract for divide) on {acc, operand}. The FSM, counter and registers stay in muldiv_sequencer.

## Test plan
- MUL, SrcA=7, SrcB=0xFFFFFFFD: Result 0xFFFFFFEB, done exactly 35 cycles after start, stall high for cycles 0–34.
- MULH, 0x80000000 × 0x80000000: Result 0x40000000. MULHU, 0xFFFFFFFF × 0xFFFFFFFF: Result 0xFFFFFFFE.
- DIV, 0xFFFFFFF9 / 2: Result 0xFFFFFFFD. REM on the same operands: Result 0xFFFFFFFF.
- DIVU, 5 / 0: Result 0xFFFFFFFF. REMU, 5 / 0: Result 5. DIV, 0x80000000 / 0xFFFFFFFF: Result 0x80000000. Latency is 2 with MULDIV_EARLY_OUT_EN and 35 without.
- flush at the 10th CALC cycle: IDLE next cycle, busy 0, no done pulse, Result keeps its prior value. A second start pulse during CALC is ignored.
- reset asserted mid-CALC: busy, done and Result all read 0 asynchronously. The first start after deassertion completes normally in 35 cycles.
